// File: rtl/regfile_read_stage.sv
// regfile_read_stage: 32 x XLEN register file with write-back port, RV32I
// operand decode, and a one-deep registered valid/ready operand stage.
// Operands are bypassed from the same-cycle write at accept and refreshed
// while a bundle is stalled, so a bundle always leaves with current values.
module regfile_read_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            use1;
    logic            use2;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
  } bundle_t;

  logic [XLEN-1:0] r_regs [NREGS];
  bundle_t         r_out;
  logic            r_vld;

  logic            w_use1, w_use2;
  logic [AW-1:0]   w_rs1, w_rs2;
  logic            w_wr_ok;
  logic            w_accept, w_fire;
  logic [XLEN-1:0] w_rd1, w_rd2;
  bundle_t         w_new;
  logic            w_unused;

  assign w_rs1    = instr[15 +: AW];
  assign w_rs2    = instr[20 +: AW];
  assign w_wr_ok  = wr_en && (wr_addr != '0);
  assign in_ready = !r_vld || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_fire   = r_vld && out_ready;
  assign w_unused = &{1'b0, instr[31:25], instr[14:12]};

  // Which source fields the opcode actually reads
  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    unique case (instr[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin w_use1 = 1'b1; w_use2 = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: w_use1 = 1'b1;
      default: ;
    endcase
  end

  // Array read with same-cycle write bypass; x0 and unused fields read as 0
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_use1 && w_rs1 != '0) w_rd1 = (w_wr_ok && wr_addr == w_rs1) ? wr_data : r_regs[w_rs1];
    if (w_use2 && w_rs2 != '0) w_rd2 = (w_wr_ok && wr_addr == w_rs2) ? wr_data : r_regs[w_rs2];
  end

  // Bundle captured on accept
  always_comb begin
    w_new        = '0;
    w_new.opcode = instr[6:0];
    w_new.rd     = instr[11:7];
    w_new.rs1    = w_rs1;
    w_new.rs2    = w_rs2;
    w_new.use1   = w_use1;
    w_new.use2   = w_use2;
    w_new.d1     = w_rd1;
    w_new.d2     = w_rd2;
  end

  // Register array write port; x0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Output stage: load on accept, drop on bare fire, refresh while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_out <= '0;
    end else if (w_accept) begin
      r_vld <= 1'b1;
      r_out <= w_new;
    end else if (w_fire) begin
      r_vld <= 1'b0;
    end else if (r_vld && w_wr_ok) begin
      if (r_out.use1 && r_out.rs1 == wr_addr) r_out.d1 <= wr_data;
      if (r_out.use2 && r_out.rs2 == wr_addr) r_out.d2 <= wr_data;
    end
  end

  assign out_valid    = r_vld;
  assign out_opcode   = r_out.opcode;
  assign out_rd       = r_out.rd;
  assign out_rs1_data = r_out.d1;
  assign out_rs2_data = r_out.d2;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: directed scenarios plus random traffic.
// A reference register file and a queue of accepted instructions give the
// expected bundle; a negedge monitor compares whenever a bundle is presented.
module tb_regfile_read_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid, out_ready;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_data, out_rs2_data;

  regfile_read_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    bit         u1, u2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t decode(input logic [31:0] ins);
    exp_t e;
    e.opcode = ins[6:0];
    e.rd     = ins[11:7];
    e.rs1    = ins[19:15];
    e.rs2    = ins[24:20];
    e.u1 = 0; e.u2 = 0;
    case (ins[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin e.u1 = 1; e.u2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: e.u1 = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor / scoreboard: a presented bundle must carry the register values
  // as of now (accept-time bypass and stall refresh both lead to that).
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else begin
      check("valid_vs_sb", {31'b0, out_valid}, {31'b0, sb.size() != 0});
      check("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (out_valid && sb.size() != 0) begin
        exp_t e;
        e = sb[0];
        check("opcode", {25'b0, out_opcode}, {25'b0, e.opcode});
        check("rd", {27'b0, out_rd}, {27'b0, e.rd});
        check("rs1_data", out_rs1_data, e.u1 ? model[e.rs1] : 32'h0);
        check("rs2_data", out_rs2_data, e.u2 ? model[e.rs2] : 32'h0);
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(decode(instr));
      if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
    end
  end

  task automatic step(input logic iv, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    in_valid = iv; instr = ins; wr_en = we; wr_addr = wa; wr_data = wd; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] r1, input logic [4:0] r2);
    logic [6:0] hi;
    logic [2:0] f3;
    hi = 7'($urandom);
    f3 = 3'($urandom);
    return {hi, r2, r1, f3, rd, op};
  endfunction

  logic [6:0] ops [10];

  initial begin
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
    reset = 1'b0;
    in_valid = 0; instr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; out_ready = 0;
    #2;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_rs1", out_rs1_data, 32'h0);
    check("rst_rs2", out_rs2_data, 32'h0);
    #20 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // LUI result then addi x6,x5,0
    step(0, 0, 1, 5, 32'h0001_2000, 1);
    step(1, 32'h0002_8313, 0, 0, 0, 1);
    check("t1_valid", {31'b0, out_valid}, 32'h1);
    check("t1_rd", {27'b0, out_rd}, 32'd6);
    check("t1_rs1", out_rs1_data, 32'h0001_2000);
    check("t1_rs2", out_rs2_data, 32'h0);

    // same-cycle write and accept: bypass to both operands
    step(1, 32'h0073_80B3, 1, 7, 32'hDEAD_BEEF, 1);
    check("t2_rs1", out_rs1_data, 32'hDEAD_BEEF);
    check("t2_rs2", out_rs2_data, 32'hDEAD_BEEF);

    // stall with bundle reading x3, refresh from write
    step(1, 32'h0001_8413, 0, 0, 0, 1);
    step(1, 32'h0000_0133, 1, 3, 32'h55, 0);
    check("t3_refresh", out_rs1_data, 32'h55);
    check("t3_in_ready", {31'b0, in_ready}, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    check("t3_one_fire", {31'b0, out_valid}, 32'h0);

    // x0 is hardwired
    step(0, 0, 1, 0, 32'hFFFF_FFFF, 1);
    step(1, 32'h0000_0133, 0, 0, 0, 1);
    check("t4_rs1", out_rs1_data, 32'h0);
    check("t4_rs2", out_rs2_data, 32'h0);

    // back-to-back stream of 4
    for (int i = 0; i < 4; i++) begin
      step(1, mk(7'b0110011, 5'(10 + i), 5, 7), 0, 0, 0, 1);
      check("t5_valid", {31'b0, out_valid}, 32'h1);
      check("t5_rd", {27'b0, out_rd}, 32'(10 + i));
    end

    // async reset mid-stream
    #2 reset = 1'b0;
    #1;
    check("t6_valid", {31'b0, out_valid}, 32'h0);
    check("t6_rs1", out_rs1_data, 32'h0);
    check("t6_rd", {27'b0, out_rd}, 32'h0);
    in_valid = 0;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    step(1, 32'h0072_8133, 0, 0, 0, 1);
    check("t6_regs_cleared_rs1", out_rs1_data, 32'h0);
    check("t6_regs_cleared_rs2", out_rs2_data, 32'h0);

    // random traffic on a small register window to force hazards
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = mk(ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)));
      step(1'($urandom), ins, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    check("drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
